// File: rtl/ultrasonic_ranger.sv
// Three-channel ultrasonic ranger: sequential m->r->l trigger/echo timing with saturating cm output.
// Optional macro RANGE_FILTER_EN averages each new result with the previous range of that channel.
module ultrasonic_ranger #(
    parameter int CYC_PER_CM  = 2900,
    parameter int TRIG_CYC    = 500,
    parameter int TIMEOUT_CYC = 1500000,
    parameter int GAP_CYC     = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       echo_m,
    input  logic       echo_r,
    input  logic       echo_l,
    output logic       trig_m,
    output logic       trig_r,
    output logic       trig_l,
    output logic [7:0] dist_m,
    output logic [7:0] dist_r,
    output logic [7:0] dist_l,
    output logic       sweep_done
);
    localparam int CW = 24;
    localparam int SW = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

    typedef enum logic [2:0] {ST_GAP, ST_TRIG, ST_WAIT_RISE, ST_MEASURE, ST_STORE} state_e;
    typedef enum logic [1:0] {CH_M, CH_R, CH_L} ch_e;

    state_e          state_q, state_d;
    ch_e             ch_q, ch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sub_q, sub_d, sub_inc;
    logic [7:0]      cm_q, cm_d, cm_inc;
    logic [2:0]      sync1_q, sync2_q, prev_q;
    logic [2:0]      trig_q, trig_d;
    logic [2:0][7:0] dist_q;
    logic            sweep_done_q;
    logic [7:0]      result, wval, prev_dist;
    logic            store_en, act, act_prev, rise, fall;

    function automatic logic pick(input logic [2:0] v, input ch_e c);
        case (c)
            CH_R:    pick = v[1];
            CH_L:    pick = v[2];
            default: pick = v[0];
        endcase
    endfunction

    // Only the active channel's synchronized echo can steer the FSM.
    assign act      = pick(sync2_q, ch_q);
    assign act_prev = pick(prev_q, ch_q);
    assign rise     = act & ~act_prev;
    assign fall     = ~act & act_prev;

    always_comb begin
        case (ch_q)
            CH_R:    prev_dist = dist_q[1];
            CH_L:    prev_dist = dist_q[2];
            default: prev_dist = dist_q[0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q + CW'(1);
        sub_d    = sub_q;
        cm_d     = cm_q;
        result   = 8'd0;
        sub_inc  = sub_q + SW'(1);
        cm_inc   = cm_q;
        if (sub_q == SW'(CYC_PER_CM - 1)) begin
            sub_inc = '0;
            cm_inc  = (cm_q == 8'd255) ? 8'd255 : cm_q + 8'd1;
        end
        case (state_q)
            ST_GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) state_d = ST_TRIG;
            end
            ST_TRIG: begin
                if (cnt_q == CW'(TRIG_CYC - 1)) state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_STORE;
                    result  = 8'd255;
                end
            end
            ST_MEASURE: begin
                // The falling cycle itself is counted, so a pulse of N*CYC_PER_CM reads N.
                if (fall) begin
                    state_d = ST_STORE;
                    result  = cm_inc;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_STORE;
                    result  = 8'd255;
                end else begin
                    sub_d = sub_inc;
                    cm_d  = cm_inc;
                end
            end
            ST_STORE: begin
                state_d = ST_GAP;
                case (ch_q)
                    CH_M:    ch_d = CH_R;
                    CH_R:    ch_d = CH_L;
                    default: ch_d = CH_M;
                endcase
            end
            default: state_d = ST_GAP;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
            sub_d = '0;
            cm_d  = '0;
        end
    end

    // Register the result on entry to STORE so dist is visible during the STORE cycle.
    assign store_en = (state_q != ST_STORE) && (state_d == ST_STORE);

    always_comb begin
        trig_d = '0;
        if (state_d == ST_TRIG) begin
            case (ch_d)
                CH_R:    trig_d[1] = 1'b1;
                CH_L:    trig_d[2] = 1'b1;
                default: trig_d[0] = 1'b1;
            endcase
        end
    end

`ifdef RANGE_FILTER_EN
    logic [2:0] seen_q;
    logic [8:0] sum;

    assign sum  = {1'b0, prev_dist} + {1'b0, result};
    assign wval = pick(seen_q, ch_q) ? sum[8:1] : result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
        end else if (store_en) begin
            case (ch_q)
                CH_R:    seen_q[1] <= 1'b1;
                CH_L:    seen_q[2] <= 1'b1;
                default: seen_q[0] <= 1'b1;
            endcase
        end
    end
`else
    logic unused_prev;
    assign unused_prev = ^prev_dist;
    assign wval        = result;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_GAP;
            ch_q         <= CH_M;
            cnt_q        <= '0;
            sub_q        <= '0;
            cm_q         <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            trig_q       <= '0;
            dist_q       <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            sync1_q      <= {echo_l, echo_r, echo_m};
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            state_q      <= state_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            sub_q        <= sub_d;
            cm_q         <= cm_d;
            trig_q       <= trig_d;
            sweep_done_q <= store_en && (ch_q == CH_L);
            if (store_en) begin
                case (ch_q)
                    CH_R:    dist_q[1] <= wval;
                    CH_L:    dist_q[2] <= wval;
                    default: dist_q[0] <= wval;
                endcase
            end
        end
    end

    assign trig_m     = trig_q[0];
    assign trig_r     = trig_q[1];
    assign trig_l     = trig_q[2];
    assign dist_m     = dist_q[0];
    assign dist_r     = dist_q[1];
    assign dist_l     = dist_q[2];
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger; echo pulses of N cycles are expected to read N/4 cm.
module tb_ultrasonic_ranger;
  localparam int CPC = 4;
  localparam int TRG = 5;
  localparam int TMO = 2000;
  localparam int GAP = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] echo = '0;
  logic       trig_m, trig_r, trig_l, sweep_done;
  logic [7:0] dist_m, dist_r, dist_l;

  int checks = 0;
  int errors = 0;
  int sd_cnt = 0;
  int exp_d[3];
  bit seen[3];

  always #5 clk = ~clk;

  ultrasonic_ranger #(.CYC_PER_CM(CPC), .TRIG_CYC(TRG), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .echo_m(echo[0]), .echo_r(echo[1]), .echo_l(echo[2]),
    .trig_m(trig_m), .trig_r(trig_r), .trig_l(trig_l),
    .dist_m(dist_m), .dist_r(dist_r), .dist_l(dist_l),
    .sweep_done(sweep_done)
  );

  function automatic logic [7:0] dist_of(input int ch);
    case (ch)
      1: return dist_r;
      2: return dist_l;
      default: return dist_m;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (sweep_done === 1'b1) sd_cnt++;
    end
  endtask

  // Reference for the stored range, including optional averaging.
  task automatic model(input int ch, input int raw);
`ifdef RANGE_FILTER_EN
    if (seen[ch]) exp_d[ch] = (exp_d[ch] + raw) / 2;
    else exp_d[ch] = raw;
`else
    exp_d[ch] = raw;
`endif
    seen[ch] = 1'b1;
  endtask

  task automatic wait_trig(input int ch);
    int n = 0;
    int w = 0;
    bit other = 0;
    logic [2:0] tv;
    logic [2:0] own;
    own = 3'b001 << ch;
    tv = {trig_l, trig_r, trig_m};
    while ((tv & own) == 3'b000 && n < 200) begin
      tick(1); n++;
      tv = {trig_l, trig_r, trig_m};
    end
    chk($sformatf("trig_seen_%0d", ch), (n < 200), 1);
    while ((tv & own) != 3'b000 && w < 50) begin
      if ((tv & ~own) != 3'b000) other = 1;
      tick(1); w++;
      tv = {trig_l, trig_r, trig_m};
    end
    chk($sformatf("trig_width_%0d", ch), w, TRG);
    chk($sformatf("trig_others_%0d", ch), other, 0);
  endtask

  task automatic run_ch(input int ch, input int w, input bit wt, input bit noise);
    logic [7:0] old;
    logic [2:0] others;
    int raw;
    others = ~(3'b001 << ch);
    if (wt) wait_trig(ch);
    tick(3);
    echo[ch] = 1'b1;
    for (int i = 0; i < w; i++) begin
      if (noise) echo = echo ^ others;
      tick(1);
    end
    echo = '0;
    old = exp_d[ch][7:0];
    raw = w / CPC;
    if (raw > 255) raw = 255;
    model(ch, raw);
    tick(2);
    chk($sformatf("dist_hold_%0d", ch), dist_of(ch), old);
    tick(1);
    chk($sformatf("dist_%0d", ch), dist_of(ch), exp_d[ch]);
  endtask

  initial begin
    int n;
    logic [7:0] old;
    for (int i = 0; i < 3; i++) begin exp_d[i] = 0; seen[i] = 0; end

    tick(3);
    chk("rst_trig", {trig_l, trig_r, trig_m}, 0);
    chk("rst_dist_m", dist_m, 0);
    chk("rst_dist_r", dist_r, 0);
    chk("rst_dist_l", dist_l, 0);
    chk("rst_sweep_done", sweep_done, 0);
    rst_n = 1'b1;
    sd_cnt = 0;

    // Nominal sweep.
    run_ch(0, 40, 1, 0);
    run_ch(1, 80, 1, 0);
    run_ch(2, 120, 1, 0);
    chk("sweep1_done", sd_cnt, 1); sd_cnt = 0;

    // Right sensor silent: timeout exactly TMO cycles into WAIT_RISE.
    run_ch(0, 40, 1, 0);
    wait_trig(1);
    old = exp_d[1][7:0];
    model(1, 255);
    tick(TMO - 1);
    chk("wait_to_hold", dist_r, old);
    tick(1);
    chk("wait_to_dist_r", dist_r, exp_d[1]);
    chk("wait_to_dist_m", dist_m, exp_d[0]);
    chk("wait_to_dist_l", dist_l, exp_d[2]);
    run_ch(2, 120, 1, 0);
    chk("sweep2_done", sd_cnt, 1); sd_cnt = 0;

    // Long pulse saturates the cm counter.
    run_ch(0, 1200, 1, 0);
    run_ch(1, 80, 1, 0);
    run_ch(2, 120, 1, 0);
    chk("sweep3_done", sd_cnt, 1); sd_cnt = 0;

    // Inactive echo lines toggling during the middle measurement.
    run_ch(0, 40, 1, 1);
    chk("noise_dist_r", dist_r, exp_d[1]);
    chk("noise_dist_l", dist_l, exp_d[2]);
    run_ch(1, 80, 1, 0);
    run_ch(2, 120, 1, 0);
    chk("sweep4_done", sd_cnt, 1); sd_cnt = 0;

    // Echo held high past the measurement limit; right channel waits meanwhile.
    wait_trig(0);
    tick(3);
    echo[0] = 1'b1;
    model(0, 255);
    tick(2100);
    chk("meas_to_dist_m", dist_m, exp_d[0]);
    tick(400);
    echo[0] = 1'b0;
    run_ch(1, 80, 0, 0);
    run_ch(2, 120, 1, 0);
    chk("sweep5_done", sd_cnt, 1); sd_cnt = 0;

    // Reset in the middle of the right channel measurement.
    run_ch(0, 40, 1, 0);
    wait_trig(1);
    tick(3);
    echo[1] = 1'b1;
    tick(20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_trig", {trig_l, trig_r, trig_m}, 0);
    chk("mid_rst_dist_m", dist_m, 0);
    chk("mid_rst_dist_r", dist_r, 0);
    chk("mid_rst_dist_l", dist_l, 0);
    chk("mid_rst_sweep_done", sweep_done, 0);
    echo = '0;
    for (int i = 0; i < 3; i++) begin exp_d[i] = 0; seen[i] = 0; end
    tick(2);
    rst_n = 1'b1;
    sd_cnt = 0;
    n = 0;
    while ({trig_l, trig_r, trig_m} == 3'b000 && n < 100) begin tick(1); n++; end
    chk("first_trig_after_rst", {trig_l, trig_r, trig_m}, 3'b001);
    n = 0;
    while (trig_m === 1'b1 && n < 50) begin tick(1); n++; end
    run_ch(0, 40, 0, 0);
    run_ch(1, 80, 1, 0);
    run_ch(2, 120, 1, 0);
    chk("sweep6_done", sd_cnt, 1); sd_cnt = 0;

    // Second middle result of 31 cm.
    run_ch(0, 124, 1, 0);
`ifdef RANGE_FILTER_EN
    chk("filter_dist_m", dist_m, 20);
`else
    chk("filter_dist_m", dist_m, 31);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ultrasonic_ranger.md
ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

Interface
REQ-001 Parameter CYC_PER_CM, default 2900: clk cycles per cm of range (58 us round trip at 50 MHz).
REQ-002 Parameter TRIG_CYC, default 500: trigger pulse width in clk cycles (10 us).
REQ-003 Parameter TIMEOUT_CYC, default 1500000: echo wait/measure limit in clk cycles (30 ms).
REQ-004 Parameter GAP_CYC, default 500000: idle cycles before each trigger (10 ms).
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 echo_m, echo_r, echo_l  input  1 each  asynchronous echo lines, middle/right/left sensors.
REQ-008 trig_m, trig_r, trig_l  output  1 each  trigger pulses, registered.
REQ-009 dist_m, dist_r, dist_l  output  8 each  range in cm, saturating at 255, held between updates.
REQ-010 sweep_done  output  1  one-cycle pulse when dist_l is written, ending an m->r->l sweep.

Function
REQ-011 Each echo input SHALL pass a 2-flop synchronizer; all echo decisions use the synchronized value and its registered copy for edge detection.
REQ-012 FSM states GAP, TRIG, WAIT_RISE, MEASURE, STORE; channel pointer cycles m->r->l->m, advancing after STORE.
REQ-013 GAP: count GAP_CYC cycles, then go to TRIG.
REQ-014 TRIG: drive only the active channel's trig high for exactly TRIG_CYC cycles; all other trig outputs low at all times.
REQ-015 WAIT_RISE: on a synchronized rising edge of the active echo go to MEASURE; echo already high on entry is not a rise; echo activity during TRIG is ignored.
REQ-016 WAIT_RISE lasting TIMEOUT_CYC cycles without a rise SHALL go to STORE with result 255.
REQ-017 MEASURE: sub-counter counts to CYC_PER_CM-1 then wraps and increments an 8-bit cm counter that saturates at 255; synchronized falling edge -> STORE with cm counter value.
REQ-018 MEASURE lasting TIMEOUT_CYC cycles SHALL go to STORE with result 255.
REQ-019 STORE lasts one cycle, writes result to the active channel's dist output only, then GAP on next channel; sweep_done pulses in that same cycle when the channel is l.
REQ-020 Latency: dist output updates one cycle after the falling edge is detected on the synchronized echo.
REQ-021 Echo lines of inactive channels SHALL have no effect.
REQ-022 Cycle counter SHALL be at least 24 bits; all counters clear on every state entry.

Reset
REQ-023 rst_n low SHALL asynchronously force: state GAP, channel m, all trig 0, dist_m/r/l 0, sweep_done 0, counters 0, synchronizers 0.
REQ-024 Reset mid-measurement SHALL discard the measurement; after release, operation restarts with GAP on channel m.

Configuration
REQ-025 Macro RANGE_FILTER_EN defined: stored value = floor((previous dist + result)/2) using a 9-bit sum, except the first write per channel after reset, which stores result raw.
REQ-026 RANGE_FILTER_EN undefined: stored value = result; no filter state logic present.

Verification (CYC_PER_CM=4, TRIG_CYC=5, TIMEOUT_CYC=2000, GAP_CYC=10)
REQ-027 Reset release, sensor models echo 40/80/120 cycles after trigger -> trig_m high 5 cycles; dist_m=10, dist_r=20, dist_l=30; one sweep_done per sweep.
REQ-028 echo_r never rises -> dist_r=255 after 2000 wait cycles; dist_m, dist_l unaffected; sweep continues to l.
REQ-029 echo_m high 1200 cycles -> dist_m=255 (saturation); echo_m held high 2500 cycles -> 255 via timeout.
REQ-030 Toggle echo_r/echo_l while channel m measures 40 cycles -> dist_m=10, dist_r/dist_l unchanged.
REQ-031 Assert rst_n low mid-MEASURE on channel r -> all outputs 0 immediately; first trigger after release is trig_m.
REQ-032 RANGE_FILTER_EN defined, dist_m measurements 10 then 31 -> dist_m=10 then 20; undefined -> 10 then 31.
